integrator_window_ctrl: RTL and testbench

INTEGRATOR_WINDOW_CTRL -- requirements
Module: integrator_window_ctrl

---
 rtl/integrator_window_ctrl.sv | 116 +++++++++++
 tb/tb_integrator_window_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/integrator_window_ctrl.sv
// Sequencer for a windowed integrator filter: it purges the SRL delay line, clears the accumulator,
// fills the window with k+3 samples, and then passes the filtered output with a valid flag.
module integrator_window_ctrl #(
    parameter int DEF_K     = 25,
    parameter int PURGE_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    input  logic [4:0]         k_cfg,
    input  logic               k_load,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               filt_reset,
    output logic               filt_enable,
    output logic [4:0]         filt_k,
    output logic signed [15:0] x_out,
    output logic signed [15:0] y_out,
    output logic               y_valid,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, CLEAR, PURGE, ZERO, FILL, RUN} state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [4:0]         k_active_q, k_active_d;
    logic [1:0]         sync_q;
    logic               filt_reset_q, filt_reset_d;
    logic               filt_enable_q, filt_enable_d;
    logic signed [15:0] y_out_q, y_out_d;
    logic               y_valid_q, y_valid_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_active_d = k_active_q;
        // Nothing moves until the reset release has passed through the synchroniser.
        if (sync_q[1]) begin
            if (k_load)
                k_active_d = (k_cfg == 5'd0) ? 5'd1 : k_cfg;
            if (state_q != IDLE && !run_en) begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end else if (k_load && state_q != IDLE) begin
                state_d = CLEAR;
                cnt_d   = 6'd0;
            end else begin
                case (state_q)
                    IDLE: if (run_en) begin
                        state_d = CLEAR;
                        cnt_d   = 6'd0;
                    end
                    CLEAR: if (cnt_q == 6'd1) begin
                        state_d = PURGE;
                        cnt_d   = 6'd0;
                    end else cnt_d = cnt_q + 6'd1;
                    PURGE: if (cnt_q == 6'(PURGE_LEN - 1)) begin
                        state_d = ZERO;
                        cnt_d   = 6'd0;
                    end else cnt_d = cnt_q + 6'd1;
                    ZERO: if (cnt_q == 6'd1) begin
                        state_d = FILL;
                        cnt_d   = 6'd0;
                    end else cnt_d = cnt_q + 6'd1;
                    FILL: if (cnt_q == {1'b0, k_active_q} + 6'd2) begin
                        state_d = RUN;
                        cnt_d   = 6'd0;
                    end else cnt_d = cnt_q + 6'd1;
                    RUN:     ;
                    default: begin
                        state_d = IDLE;
                        cnt_d   = 6'd0;
                    end
                endcase
            end
        end
        // Filter controls are registered alongside the state, so they track state_q exactly.
        filt_reset_d  = (state_d == IDLE) || (state_d == CLEAR) || (state_d == ZERO);
        filt_enable_d = !filt_reset_d;
        y_valid_d     = (state_q == RUN) && (state_d == RUN);
        y_out_d       = (state_q == RUN) ? y_in : y_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= 2'b00;
            state_q       <= IDLE;
            cnt_q         <= 6'd0;
            k_active_q    <= 5'(DEF_K);
            filt_reset_q  <= 1'b1;
            filt_enable_q <= 1'b0;
            y_out_q       <= '0;
            y_valid_q     <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], 1'b1};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_active_q    <= k_active_d;
            filt_reset_q  <= filt_reset_d;
            filt_enable_q <= filt_enable_d;
            y_out_q       <= y_out_d;
            y_valid_q     <= y_valid_d;
        end
    end

    assign filt_reset  = filt_reset_q;
    assign filt_enable = filt_enable_q;
    assign filt_k      = k_active_q;
    assign x_out       = (state_q == FILL || state_q == RUN) ? x_in : 16'sd0;
    assign y_out       = y_out_q;
    assign y_valid     = y_valid_q;
    assign busy        = (state_q == CLEAR) || (state_q == PURGE) ||
                         (state_q == ZERO)  || (state_q == FILL);

endmodule

// File: tb/tb_integrator_window_ctrl.sv
// Directed bench for integrator_window_ctrl: bring-up, reconfig, clamp, abort, collision, async reset.
module tb_integrator_window_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               run_en;
    logic [4:0]         k_cfg;
    logic               k_load;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               filt_reset;
    logic               filt_enable;
    logic [4:0]         filt_k;
    logic signed [15:0] x_out;
    logic signed [15:0] y_out;
    logic               y_valid;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    integrator_window_ctrl #(.DEF_K(25), .PURGE_LEN(32)) dut (
        .clk(clk), .reset(reset), .run_en(run_en), .k_cfg(k_cfg), .k_load(k_load),
        .x_in(x_in), .y_in(y_in), .filt_reset(filt_reset), .filt_enable(filt_enable),
        .filt_k(filt_k), .x_out(x_out), .y_out(y_out), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int cycles = 1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Phase as seen from outputs: 0 idle, 1 clear/zero, 2 purge, 4 fill, 5 run (x_in kept nonzero).
    function automatic int phase();
        if (!busy) return filt_enable ? 5 : 0;
        if (filt_reset) return 1;
        if (x_out == 16'sd0 && x_in != 16'sd0) return 2;
        return 4;
    endfunction

    task automatic count_phase(input int ph, output int cnt);
        cnt = 0;
        while (phase() == ph && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic pulse_k(input logic [4:0] k);
        k_cfg  = k;
        k_load = 1'b1;
        tick();
        k_load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run_en = 1'b0; k_cfg = 5'd0; k_load = 1'b0;
        x_in = 16'sd100; y_in = 16'sd2500;
        tick(3);
        chk("rst_filt_reset", 32'(filt_reset), 32'd1);
        chk("rst_filt_enable", 32'(filt_enable), 32'd0);
        chk("rst_filt_k", 32'(filt_k), 32'd25);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);

        // Release with run_en already high: two synchroniser cycles of nothing.
        reset = 1'b1; run_en = 1'b1;
        tick(2);
        chk("sync_hold_busy", 32'(busy), 32'd0);
        tick();
        chk("sync_start_busy", 32'(busy), 32'd1);

        count_phase(1, n); chk("up_clear_len", n, 2);
        count_phase(2, n); chk("up_purge_len", n, 32);
        count_phase(1, n); chk("up_zero_len", n, 2);
        x_in = 16'sd123; #1;
        chk("fill_x_pass", 32'(x_out), 32'(16'sd123));
        x_in = 16'sd100;
        chk("fill_y_valid", 32'(y_valid), 32'd0);
        count_phase(4, n); chk("up_fill_len", n, 28);
        chk("run_phase", phase(), 5);
        chk("run_first_y_valid", 32'(y_valid), 32'd0);
        tick();
        chk("run_y_valid", 32'(y_valid), 32'd1);
        chk("run_y_out", 32'(y_out), 32'd2500);

        // Reconfigure to k=10 from RUN.
        pulse_k(5'd10);
        chk("rc_filt_k", 32'(filt_k), 32'd10);
        chk("rc_y_valid", 32'(y_valid), 32'd0);
        y_in = 16'sd9;
        tick();
        chk("rc_y_out_hold", 32'(y_out), 32'd2500);
        count_phase(1, n); chk("rc_clear_len", n, 1);
        count_phase(2, n); chk("rc_purge_len", n, 32);
        count_phase(1, n); chk("rc_zero_len", n, 2);
        count_phase(4, n); chk("rc_fill_len", n, 13);
        tick();
        chk("rc_y_valid_run", 32'(y_valid), 32'd1);
        chk("rc_y_out_run", 32'(y_out), 32'd9);

        // Clamp k_cfg=0 to 1.
        pulse_k(5'd0);
        chk("cl_filt_k", 32'(filt_k), 32'd1);
        count_phase(1, n); chk("cl_clear_len", n, 2);
        count_phase(2, n); chk("cl_purge_len", n, 32);
        count_phase(1, n); chk("cl_zero_len", n, 2);
        count_phase(4, n); chk("cl_fill_len", n, 4);

        // Abort during PURGE cycle 15.
        pulse_k(5'd25);
        count_phase(1, n); chk("ab_clear_len", n, 2);
        tick(14);
        chk("ab_in_purge", phase(), 2);
        run_en = 1'b0;
        tick();
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_filt_reset", 32'(filt_reset), 32'd1);
        chk("ab_x_out", 32'(x_out), 32'd0);
        tick(2);
        chk("ab_stays_idle", phase(), 0);

        // Collision in FILL: run_en drop wins, k still latched.
        run_en = 1'b1;
        tick();
        count_phase(1, n); chk("co_clear_len", n, 2);
        count_phase(2, n); chk("co_purge_len", n, 32);
        count_phase(1, n); chk("co_zero_len", n, 2);
        tick(2);
        chk("co_in_fill", phase(), 4);
        run_en = 1'b0;
        pulse_k(5'd7);
        chk("co_busy", 32'(busy), 32'd0);
        chk("co_filt_reset", 32'(filt_reset), 32'd1);
        chk("co_filt_k", 32'(filt_k), 32'd7);

        // Restart to RUN with k=7, then async reset between edges.
        run_en = 1'b1;
        tick();
        count_phase(1, n);
        count_phase(2, n);
        count_phase(1, n);
        count_phase(4, n); chk("k7_fill_len", n, 10);
        y_in = 16'sd555;
        tick();
        chk("k7_y_valid", 32'(y_valid), 32'd1);
        chk("k7_y_out", 32'(y_out), 32'd555);
        #2 reset = 1'b0;
        #1;
        chk("ar_filt_reset", 32'(filt_reset), 32'd1);
        chk("ar_filt_enable", 32'(filt_enable), 32'd0);
        chk("ar_y_valid", 32'(y_valid), 32'd0);
        chk("ar_y_out", 32'(y_out), 32'd0);
        chk("ar_filt_k", 32'(filt_k), 32'd25);
        chk("ar_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("ar_sync_hold", 32'(busy), 32'd0);
        tick();
        chk("ar_restart", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
